// File: rtl/ahb_periph_bridge.sv
// ahb_periph_bridge
//
// AHB-Lite slave that drives the simple peripheral register bus. Each accepted
// AHB word transfer becomes exactly one peripheral access. The AHB data phase
// is stretched while the peripheral holds ready low. Peripheral write errors
// and illegal transfers return the two-cycle AHB ERROR response.
//
// Build option:
//   PERIPH_TIMEOUT_EN - when defined, a read that sees ready=0 for
//                       TIMEOUT_CYCLES data-phase cycles is aborted with ERROR.
//                       When undefined, a read waits for ready indefinitely.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   HSEL..HREADY    AHB-Lite slave inputs (address phase + HWDATA in data phase)
//   HREADYOUT       slave ready
//   HRESP           0 = OKAY, 1 = ERROR
//   HRDATA          registered read data, held until the next completed read
//   rd_en, wr_en    peripheral strobes, never both high
//   address         latched HADDR, held between accesses
//   wr_data         HWDATA while writing, 0 otherwise
//   rd_data, ready  peripheral read data and its valid
//   error           peripheral write error, valid the cycle after wr_en

module ahb_periph_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  rd_en,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  ready,
    input  logic                  error
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWchk,
        StWdone,
        StRead,
        StRdone,
        StErr1,
        StErr2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
    logic                  hready_int;
    logic                  trans_active;
    logic                  illegal;

`ifdef PERIPH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
`endif

    // NONSEQ or SEQ; IDLE and BUSY never start an access.
    assign trans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    // Only aligned word transfers are supported by the peripheral bus.
    assign illegal      = (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        hrdata_d   = hrdata_q;
        hready_int = 1'b1;
        HRESP      = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
`ifdef PERIPH_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif

        case (state_q)
            StWrite: begin
                wr_en      = 1'b1;
                wr_data    = HWDATA;
                hready_int = 1'b0;
                state_d    = StWchk;
            end
            StWchk: begin
                hready_int = 1'b0;
                state_d    = error ? StErr1 : StWdone;
            end
            StRead: begin
                rd_en      = 1'b1;
                hready_int = 1'b0;
                if (ready) begin
                    hrdata_d = rd_data;
                    state_d  = StRdone;
                end
`ifdef PERIPH_TIMEOUT_EN
                // ready in the final counted cycle has already won above.
                else if (wait_cnt_q == CntLast) begin
                    state_d = StErr1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            StErr1: begin
                hready_int = 1'b0;
                HRESP      = 1'b1;
                state_d    = StErr2;
            end
            StErr2: begin
                HRESP   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                // StIdle, StWdone, StRdone: fall back to idle unless a new
                // transfer is accepted below.
                state_d = StIdle;
            end
        endcase

        // Address phases are taken in every state that shows HREADYOUT=1.
        if (hready_int && HSEL && HREADY && trans_active) begin
            address_d = HADDR;
            if (illegal) begin
                state_d = StErr1;
            end else if (HWRITE) begin
                state_d = StWrite;
            end else begin
                state_d = StRead;
`ifdef PERIPH_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            address_q <= '0;
            hrdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            hrdata_q  <= hrdata_d;
        end
    end

`ifdef PERIPH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign HREADYOUT = hready_int;
    assign HRDATA    = hrdata_q;
    assign address   = address_q;

endmodule

// File: tb/tb_ahb_periph_bridge.sv
// Randomized scoreboard bench for ahb_periph_bridge. A driver issues AHB
// transfers and pushes the expected data-phase outcome into a queue; a monitor
// watches the bus, measures each data phase and compares it on completion.

module tb_ahb_periph_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 16;
`ifdef PERIPH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          HSEL;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [DW-1:0] HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [DW-1:0] HRDATA;
    logic          rd_en;
    logic          wr_en;
    logic [AW-1:0] address;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          ready;
    logic          error;

    always #5 clk = ~clk;

    ahb_periph_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP),
        .HRDATA   (HRDATA),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .address  (address),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .ready    (ready),
        .error    (error)
    );

    // Single-slave system: the bus HREADY is this slave's HREADYOUT.
    assign HREADY = HREADYOUT;

    // ---------------- checking bookkeeping ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // ---------------- peripheral model ----------------
    int          cur_rdelay = 0;
    logic [31:0] cur_rdata  = '0;
    logic        cur_werr   = 1'b0;
    int          rcnt;
    logic        wr_prev;
    logic        junk_err   = 1'b0;
    logic        junk_rdy   = 1'b0;
    logic [31:0] junk_data  = '0;

    always @(negedge clk) begin
        junk_err  <= 1'($urandom % 2);
        junk_rdy  <= 1'($urandom % 2);
        junk_data <= $urandom;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt    <= 0;
            wr_prev <= 1'b0;
        end else begin
            rcnt    <= (rd_en && !ready) ? rcnt + 1 : 0;
            wr_prev <= wr_en;
        end
    end

    // Outside a read / write-check the peripheral lines carry noise.
    assign ready   = rd_en ? (rcnt == cur_rdelay) : junk_rdy;
    assign rd_data = (rd_en && rcnt == cur_rdelay) ? cur_rdata : junk_data;
    assign error   = wr_prev ? cur_werr : junk_err;

    // ---------------- reference model ----------------
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          rdelay;
        bit          werr;
        logic [31:0] rdata;
        int          gap;
    } txn_t;

    typedef struct {
        bit          resp;
        int          cycles;
        int          nwr;
        int          nrd;
        bit          chk_addr;
        logic [31:0] addr;
        bit          chk_wdata;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] model_hrdata = '0;

    function automatic exp_t predict(input txn_t t);
        exp_t e;
        e.chk_addr  = 1'b0;
        e.chk_wdata = 1'b0;
        e.addr      = t.addr;
        e.wdata     = t.wdata;
        e.nwr       = 0;
        e.nrd       = 0;
        if (t.size != 3'd2 || t.addr[1:0] != 2'b00) begin
            e.resp   = 1'b1;
            e.cycles = 2;
        end else if (t.wr) begin
            e.chk_addr  = 1'b1;
            e.chk_wdata = 1'b1;
            e.nwr       = 1;
            e.resp      = t.werr;
            e.cycles    = t.werr ? 4 : 3;
        end else begin
            e.chk_addr = 1'b1;
            if (TO_EN && t.rdelay >= T) begin
                e.resp   = 1'b1;
                e.cycles = T + 2;
                e.nrd    = T;
            end else begin
                e.resp       = 1'b0;
                e.cycles     = t.rdelay + 2;
                e.nrd        = t.rdelay + 1;
                model_hrdata = t.rdata;
            end
        end
        e.rdata = model_hrdata;
        return e;
    endfunction

    // ---------------- driver ----------------
    bit mon_en = 1'b0;

    task automatic wait_accept();
        int n = 0;
        bit rdy;
        do begin
            @(negedge clk);
            rdy = HREADYOUT;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 300);
        if (!rdy) check("hreadyout_timeout", 0, 1);
    endtask

    task automatic drive_idle();
        int k = int'($urandom_range(0, 2));
        HSEL   = (k != 0);
        HTRANS = (k == 2) ? 2'b01 : 2'b00;
        HADDR  = $urandom;
        HWRITE = 1'($urandom % 2);
        HSIZE  = 3'($urandom);
    endtask

    task automatic issue(input txn_t t);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = t.addr;
        HWRITE = t.wr;
        HSIZE  = t.size;
        wait_accept();
        HWDATA     = t.wr ? t.wdata : $urandom;
        cur_rdelay = t.rdelay;
        cur_rdata  = t.rdata;
        cur_werr   = t.werr;
        expq.push_back(predict(t));
        if (t.gap > 0) begin
            drive_idle();
            repeat (t.gap) wait_accept();
        end
    endtask

    function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                                input logic [31:0] wdata, input int rdelay, input bit werr,
                                input logic [31:0] rdata, input int gap);
        txn_t t;
        t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata;
        t.rdelay = rdelay; t.werr = werr; t.rdata = rdata; t.gap = gap;
        return t;
    endfunction

    // ---------------- monitor ----------------
    int overlap_cnt = 0;
    int wd_viol_cnt = 0;

    initial begin : monitor
        bit          in_dp = 1'b0;
        int          cyc = 0, nwr = 0, nrd = 0;
        logic [31:0] a = '0, wd = '0;
        bit          prv_rdy = 1'b1, prv_resp = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                in_dp = 1'b0;
                continue;
            end
            if (rd_en && wr_en) overlap_cnt++;
            if (!wr_en && wr_data != '0) wd_viol_cnt++;
            if (in_dp) begin
                cyc++;
                if (wr_en) begin nwr++; a = address; wd = wr_data; end
                if (rd_en) begin nrd++; a = address; end
                if (HREADYOUT) begin
                    if (expq.size() == 0) begin
                        check("unexpected_completion", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        check("hresp", 64'(HRESP), 64'(e.resp));
                        check("data_phase_cycles", 64'(cyc), 64'(e.cycles));
                        check("wr_en_cycles", 64'(nwr), 64'(e.nwr));
                        check("rd_en_cycles", 64'(nrd), 64'(e.nrd));
                        check("hrdata", 64'(HRDATA), 64'(e.rdata));
                        if (e.chk_addr) check("periph_address", 64'(a), 64'(e.addr));
                        if (e.chk_wdata) check("periph_wr_data", 64'(wd), 64'(e.wdata));
                        if (e.resp) check("error_first_cycle", {62'd0, prv_rdy, prv_resp}, 64'd1);
                    end
                    in_dp = 1'b0;
                end else begin
                    prv_rdy  = HREADYOUT;
                    prv_resp = HRESP;
                end
            end
            if (HSEL && HTRANS[1] && HREADYOUT) begin
                in_dp = 1'b1;
                cyc = 0; nwr = 0; nrd = 0;
                prv_rdy = 1'b1; prv_resp = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        txn_t t;
        int   n;
        rst = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'd2; HWDATA = '0;
        #12;
        check("reset_hreadyout", 64'(HREADYOUT), 64'd1);
        check("reset_hresp", 64'(HRESP), 64'd0);
        check("reset_hrdata", 64'(HRDATA), 64'd0);
        check("reset_strobes", {62'd0, rd_en, wr_en}, 64'd0);
        check("reset_address", 64'(address), 64'd0);
        check("reset_wr_data", 64'(wr_data), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        issue(mk(1, 32'h4000_0004, 3'd2, 32'h64, 0, 0, 0, 1));
        issue(mk(0, 32'h4000_0010, 3'd2, 0, 3, 0, 32'h1234, 1));
        issue(mk(1, 32'h4000_0020, 3'd2, 32'h55, 0, 1, 0, 0));
        issue(mk(0, 32'h4000_0024, 3'd2, 0, 0, 0, 32'hA5A5, 1));
        issue(mk(1, 32'h4000_0030, 3'd0, 32'h77, 0, 0, 0, 1));
        issue(mk(0, 32'h4000_0006, 3'd2, 0, 0, 0, 32'h9999, 1));
        issue(mk(1, 32'h4000_0000, 3'd2, 32'hDEAD, 0, 0, 0, 0));
        issue(mk(0, 32'h4000_0000, 3'd2, 0, 1, 0, 32'hBEEF, 1));
        issue(mk(0, 32'h4000_0040, 3'd2, 0, 20, 0, 32'hCAFE, 1));
        issue(mk(0, 32'h4000_0044, 3'd2, 0, T - 1, 0, 32'h1111, 1));

        for (int i = 0; i < 60; i++) begin
            t.wr     = bit'($urandom % 2);
            t.addr   = {16'h4000, 16'($urandom)};
            t.addr[1:0] = ($urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            t.size   = ($urandom % 8 == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
            t.wdata  = $urandom;
            t.rdelay = ($urandom % 6 == 0) ? int'($urandom_range(14, 18))
                                           : int'($urandom_range(0, 5));
            t.werr   = ($urandom % 4 == 0);
            t.rdata  = $urandom;
            t.gap    = int'($urandom_range(0, 2));
            issue(t);
        end
        drive_idle();

        n = 0;
        while (expq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(expq.size()), 64'd0);
        @(negedge clk);
        mon_en = 1'b0;

        // Reset in the middle of a long read drops everything at once.
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4000_0008; HWRITE = 1'b0; HSIZE = 3'd2;
        wait_accept();
        cur_rdelay = 1000;
        HSEL = 1'b0; HTRANS = 2'b00;
        repeat (5) @(posedge clk);
        #2;
        check("rd_en_before_reset", 64'(rd_en), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_read_reset_rd_en", 64'(rd_en), 64'd0);
        check("mid_read_reset_hreadyout", 64'(HREADYOUT), 64'd1);
        check("mid_read_reset_hresp", 64'(HRESP), 64'd0);
        check("mid_read_reset_hrdata", 64'(HRDATA), 64'd0);
        check("mid_read_reset_address", 64'(address), 64'd0);

        check("strobe_overlap_cycles", 64'(overlap_cnt), 64'd0);
        check("wr_data_nonzero_outside_write", 64'(wd_viol_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ahb_periph_bridge.md
Name: ahb_periph_bridge

Overview:
- AHB-Lite slave that acts as the initiator on the simple peripheral register bus (rd_en / wr_en / address / wr_data / rd_data / ready / error) used by the system's memory-mapped peripherals, such as the timer.
- Converts each AHB word transfer into exactly one peripheral access.
- Stretches the AHB data phase while the peripheral holds ready low, and maps peripheral write errors, illegal transfers and timeouts to the two-cycle AHB ERROR response.

Parameters:
ADDR_WIDTH, 32, width of HADDR and peripheral address
DATA_WIDTH, 32, width of HWDATA/HRDATA and peripheral data
TIMEOUT_CYCLES, 16, maximum data-phase cycles spent waiting for ready=1 on a read (used only with the optional feature)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
HSEL  input  1  slave select
HADDR  input  ADDR_WIDTH  address-phase address
HTRANS  input  2  transfer type (IDLE/BUSY/NONSEQ/SEQ)
HWRITE  input  1  1 = write
HSIZE  input  3  transfer size
HWDATA  input  DATA_WIDTH  write data (data phase)
HREADY  input  1  system ready; previous transfer complete
HREADYOUT  output  1  slave ready
HRESP  output  1  0 = OKAY, 1 = ERROR
HRDATA  output  DATA_WIDTH  read data
rd_en  output  1  peripheral read strobe
wr_en  output  1  peripheral write strobe
address  output  ADDR_WIDTH  peripheral address (latched HADDR)
wr_data  output  DATA_WIDTH  peripheral write data
rd_data  input  DATA_WIDTH  peripheral read data
ready  input  1  peripheral read data valid
error  input  1  peripheral write error, valid the cycle after wr_en

Behaviour:
- Reset values (async, rst=0):
  - state=IDLE; HREADYOUT=1, HRESP=0, HRDATA=0.
  - rd_en=0, wr_en=0, address=0, wr_data=0; wait counter=0.
  - Reset mid-access drops the strobes immediately; no completion is issued.
- Accept an address phase when HSEL & HTRANS[1] & HREADY, in any state presenting HREADYOUT=1 (IDLE, WDONE, RDONE, ERR2).
  - On accept, latch HADDR, HWRITE and HSIZE.
- Illegal transfer → ERR1, with no peripheral strobe. Illegal means either:
  - HSIZE != 3'b010, or
  - HADDR[1:0] != 0.
- HTRANS IDLE/BUSY, or HSEL=0: no access; zero-wait OKAY; stay in or return to IDLE.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. Legal accept → WRITE (HWRITE=1) or READ (HWRITE=0).
  - WRITE: wr_en=1, address=latched, wr_data=HWDATA, HREADYOUT=0. Always → WCHK after 1 cycle.
  - WCHK: wr_en=0, HREADYOUT=0. Sample error: 0 → WDONE; 1 → ERR1.
  - WDONE: HREADYOUT=1, HRESP=OKAY. Accept rules apply, else → IDLE.
    - Write data phase = 3 cycles (2 wait states).
  - READ: rd_en=1, address=latched, HREADYOUT=0.
    - ready=1 → register rd_data into HRDATA, → RDONE.
    - ready=0 → stay and increment the wait counter.
  - RDONE: rd_en=0, HREADYOUT=1, HRESP=OKAY, HRDATA valid. Accept rules apply, else → IDLE.
    - Minimum read data phase = 2 cycles.
  - ERR1: HREADYOUT=0, HRESP=1. → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accept rules apply; the master may cancel with HTRANS=IDLE.
- Strobe rules:
  - rd_en and wr_en are never both 1.
  - Each is asserted only in its own state.
  - wr_en is high for exactly one cycle per write.
  - error is ignored outside WCHK; ready is ignored outside READ.
- HRDATA holds its last value until the next RDONE; it is 0 after reset.
- address holds its last latched value between accesses; wr_data=0 outside WRITE.
- The wait counter clears on every entry to READ.

Optional Feature:
- Macro: PERIPH_TIMEOUT_EN.
- Defined:
  - If READ has lasted TIMEOUT_CYCLES cycles with ready=0, drop rd_en and go to ERR1.
  - HRDATA is not updated.
  - A ready=1 in the final counted cycle wins over the timeout.
- Undefined:
  - The counter logic is absent.
  - READ waits indefinitely for ready, e.g. a status register that holds ready low until an event.

Test Plan:
- Write HADDR=0x4000_0004, HWDATA=0x64, error=0 → wr_en high 1 cycle with address=0x4000_0004 and wr_data=0x64; HREADYOUT low 2 cycles; OKAY.
- Read 0x4000_0010 with ready low 3 cycles, then rd_data=0x1234 → rd_en high 4 cycles; HRDATA=0x1234 in RDONE; OKAY after 5 data-phase cycles.
- Write 0x4000_0020 with peripheral error=1 in WCHK → HRESP=1 with HREADYOUT=0, then HRESP=1 with HREADYOUT=1; next NONSEQ accepted in ERR2.
- HSIZE=3'b000 write, and separately HADDR=0x4000_0006 → ERROR response; rd_en and wr_en never asserted.
- With PERIPH_TIMEOUT_EN and TIMEOUT_CYCLES=16, read with ready stuck 0 → rd_en drops after 16 cycles, ERROR response, HRDATA unchanged; without the macro, rd_en stays high.
- Back-to-back NONSEQ write 0x4000_0000 then read 0x4000_0000 → read address phase accepted in WDONE; rd_en asserts next cycle; no overlap with wr_en; assert rst low mid-READ → rd_en=0 and HREADYOUT=1 immediately.
